// File: rtl/lcd_ball_pkg.sv
// Shared types and constants for the ball bounding-box overlay stage.
// Contains the FSM state type, the coordinate width, the RGB565 field
// slices and the saturating coordinate arithmetic.
package lcd_ball_pkg;

  localparam int COORD_W = 11;

  // RGB565 field positions
  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    ACCUM      = 2'd1,
    LATCH      = 2'd2
  } state_t;

  // a + b in COORD_W+1 bits, clamped to the top of the coordinate range
  function automatic coord_t sat_add(coord_t a, coord_t b);
    logic [COORD_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[COORD_W] ? {COORD_W{1'b1}} : s[COORD_W-1:0];
  endfunction

  // a - b, clamped at zero
  function automatic coord_t sat_sub(coord_t a, coord_t b);
    return (a < b) ? '0 : coord_t'(a - b);
  endfunction

  function automatic logic in_range(coord_t v, coord_t lo, coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/lcd_ball_box_if.sv
// Pixel stream between the LCD timing driver and the ball-box stage,
// plus the exported latched box. master = driver side, slave = stage.
interface lcd_ball_box_if;
  import lcd_ball_pkg::*;

  logic        in_vsync;
  logic        pre_de;
  logic [15:0] pre_rgb;
  coord_t      pixel_xpos;
  coord_t      pixel_ypos;
  logic [15:0] post_rgb;
  logic        post_de;
  logic        box_valid;
  coord_t      x_min_o;
  coord_t      x_max_o;
  coord_t      y_min_o;
  coord_t      y_max_o;

  modport master (
    output in_vsync, pre_de, pre_rgb, pixel_xpos, pixel_ypos,
    input  post_rgb, post_de, box_valid, x_min_o, x_max_o, y_min_o, y_max_o
  );

  modport slave (
    input  in_vsync, pre_de, pre_rgb, pixel_xpos, pixel_ypos,
    output post_rgb, post_de, box_valid, x_min_o, x_max_o, y_min_o, y_max_o
  );

endinterface

// File: rtl/ball_color_match.sv
// Combinational RGB565 colour threshold: red at least R_MIN, green and
// blue at most G_MAX / B_MAX. Kept separate so a binary-mask view can
// reuse it.
module ball_color_match
  import lcd_ball_pkg::*;
#(
  parameter logic [4:0] R_MIN = 5'd20,
  parameter logic [5:0] G_MAX = 6'd24,
  parameter logic [4:0] B_MAX = 5'd12
) (
  input  logic        de,
  input  logic [15:0] rgb,
  output logic        hit
);

  assign hit = de
             & (rgb[R_MSB:R_LSB] >= R_MIN)
             & (rgb[G_MSB:G_LSB] <= G_MAX)
             & (rgb[B_MSB:B_LSB] <= B_MAX);

endmodule

// File: rtl/lcd_ball_box.sv
// Ball bounding-box stage: accumulates the box of colour-matching pixels
// over a frame, latches it during vertical blanking and overlays it as a
// rectangle on following frames with one cycle of pixel latency.
// Optional: define BALL_CROSS_EN to also draw a centre crosshair.
module lcd_ball_box
  import lcd_ball_pkg::*;
#(
  parameter logic [4:0]  R_MIN     = 5'd20,
  parameter logic [5:0]  G_MAX     = 6'd24,
  parameter logic [4:0]  B_MAX     = 5'd12,
  parameter logic [15:0] MIN_PIX   = 16'd64,
  parameter int          LINE_W    = 2,
  parameter logic [15:0] BOX_COLOR = 16'h07E0
) (
  input  logic           lcd_clk,
  input  logic           sys_rst,
  lcd_ball_box_if.slave  bus
);

  localparam coord_t LW_M1    = coord_t'(LINE_W - 1);
  localparam coord_t CROSS_R  = coord_t'(4);
  localparam coord_t COORD_HI = {COORD_W{1'b1}};

  logic   hit;
  logic   vsync_d, vs_rise;
  state_t state, state_nxt;
  logic   acc_clr, latch_en;

  coord_t      acc_xmin, acc_xmax, acc_ymin, acc_ymax;
  logic [15:0] pix_cnt;

  logic   box_valid;
  coord_t x_min_o, x_max_o, y_min_o, y_max_o;

  logic [15:0] post_rgb;
  logic        post_de;

  ball_color_match #(
    .R_MIN (R_MIN),
    .G_MAX (G_MAX),
    .B_MAX (B_MAX)
  ) u_match (
    .de  (bus.pre_de),
    .rgb (bus.pre_rgb),
    .hit (hit)
  );

  assign vs_rise = bus.in_vsync & ~vsync_d;

  // State register and the one-cycle vsync delay used for edge detection
  always_ff @(posedge lcd_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state   <= WAIT_FRAME;
      vsync_d <= 1'b0;
    end else begin
      state   <= state_nxt;
      vsync_d <= bus.in_vsync;
    end
  end

  // Next state: wait for active video, accumulate until vsync rises, latch once
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_FRAME: if (!bus.in_vsync) state_nxt = ACCUM;
      ACCUM:      if (vs_rise)       state_nxt = LATCH;
      LATCH:                         state_nxt = WAIT_FRAME;
      default:                       state_nxt = WAIT_FRAME;
    endcase
  end

  // State decode: accumulators are held cleared outside ACCUM
  always_comb begin
    acc_clr  = (state != ACCUM);
    latch_en = (state == LATCH);
  end

  // Bounding-box and pixel-count accumulation over the current frame
  always_ff @(posedge lcd_clk or posedge sys_rst) begin
    if (sys_rst) begin
      acc_xmin <= COORD_HI;
      acc_ymin <= COORD_HI;
      acc_xmax <= '0;
      acc_ymax <= '0;
      pix_cnt  <= '0;
    end else if (acc_clr) begin
      acc_xmin <= COORD_HI;
      acc_ymin <= COORD_HI;
      acc_xmax <= '0;
      acc_ymax <= '0;
      pix_cnt  <= '0;
    end else if (hit) begin
      if (bus.pixel_xpos < acc_xmin) acc_xmin <= bus.pixel_xpos;
      if (bus.pixel_xpos > acc_xmax) acc_xmax <= bus.pixel_xpos;
      if (bus.pixel_ypos < acc_ymin) acc_ymin <= bus.pixel_ypos;
      if (bus.pixel_ypos > acc_ymax) acc_ymax <= bus.pixel_ypos;
      if (pix_cnt != 16'hFFFF) pix_cnt <= pix_cnt + 16'd1;
    end
  end

  // Latch the box during blanking; a weak frame invalidates but keeps coords
  always_ff @(posedge lcd_clk or posedge sys_rst) begin
    if (sys_rst) begin
      box_valid <= 1'b0;
      x_min_o   <= '0;
      x_max_o   <= '0;
      y_min_o   <= '0;
      y_max_o   <= '0;
    end else if (latch_en) begin
      if (pix_cnt >= MIN_PIX) begin
        box_valid <= 1'b1;
        x_min_o   <= acc_xmin;
        x_max_o   <= acc_xmax;
        y_min_o   <= acc_ymin;
        y_max_o   <= acc_ymax;
      end else begin
        box_valid <= 1'b0;
      end
    end
  end

  // Edge bands. Bounds saturate instead of wrapping, and each band is also
  // limited to the box so a box narrower than LINE_W draws only its own area.
  coord_t xl_hi, xr_lo, yt_hi, yb_lo;
  logic   on_v, on_h, on_c;

  // Rectangle hit test for the current pixel against the latched box
  always_comb begin
    xl_hi = sat_add(x_min_o, LW_M1);
    if (xl_hi > x_max_o) xl_hi = x_max_o;
    xr_lo = sat_sub(x_max_o, LW_M1);
    if (xr_lo < x_min_o) xr_lo = x_min_o;
    yt_hi = sat_add(y_min_o, LW_M1);
    if (yt_hi > y_max_o) yt_hi = y_max_o;
    yb_lo = sat_sub(y_max_o, LW_M1);
    if (yb_lo < y_min_o) yb_lo = y_min_o;

    on_v = (in_range(bus.pixel_xpos, x_min_o, xl_hi) |
            in_range(bus.pixel_xpos, xr_lo, x_max_o)) &
           in_range(bus.pixel_ypos, y_min_o, y_max_o);
    on_h = (in_range(bus.pixel_ypos, y_min_o, yt_hi) |
            in_range(bus.pixel_ypos, yb_lo, y_max_o)) &
           in_range(bus.pixel_xpos, x_min_o, x_max_o);
  end

`ifdef BALL_CROSS_EN
  coord_t           cx, cy;
  logic [COORD_W:0] sum_x, sum_y;

  assign sum_x = {1'b0, acc_xmin} + {1'b0, acc_xmax};
  assign sum_y = {1'b0, acc_ymin} + {1'b0, acc_ymax};

  // Centre is computed with the latch so the pixel path stays one cycle
  always_ff @(posedge lcd_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cx <= '0;
      cy <= '0;
    end else if (latch_en && (pix_cnt >= MIN_PIX)) begin
      cx <= sum_x[COORD_W:1];
      cy <= sum_y[COORD_W:1];
    end
  end

  assign on_c = ((bus.pixel_ypos == cy) &
                 in_range(bus.pixel_xpos, sat_sub(cx, CROSS_R), sat_add(cx, CROSS_R))) |
                ((bus.pixel_xpos == cx) &
                 in_range(bus.pixel_ypos, sat_sub(cy, CROSS_R), sat_add(cy, CROSS_R)));
`else
  assign on_c = 1'b0;
`endif

  // One-cycle pixel path; output colour is forced to zero outside active video
  always_ff @(posedge lcd_clk or posedge sys_rst) begin
    if (sys_rst) begin
      post_de  <= 1'b0;
      post_rgb <= '0;
    end else begin
      post_de <= bus.pre_de;
      if (!bus.pre_de)
        post_rgb <= '0;
      else if (box_valid & (on_v | on_h | on_c))
        post_rgb <= BOX_COLOR;
      else
        post_rgb <= bus.pre_rgb;
    end
  end

  assign bus.post_rgb  = post_rgb;
  assign bus.post_de   = post_de;
  assign bus.box_valid = box_valid;
  assign bus.x_min_o   = x_min_o;
  assign bus.x_max_o   = x_max_o;
  assign bus.y_min_o   = y_min_o;
  assign bus.y_max_o   = y_max_o;

endmodule

// File: tb/tb_lcd_ball_box.sv
// Directed bench for lcd_ball_box with default parameters. Frames are
// abstract: a few blanking cycles with in_vsync high, then arbitrary
// pixels at chosen coordinates. Crosshair expectations follow BALL_CROSS_EN.
module tb_lcd_ball_box;

  localparam logic [15:0] GRN  = 16'h07E0;
  localparam logic [15:0] RED  = 16'hF800;
  localparam logic [15:0] BLU  = 16'h001F;
`ifdef BALL_CROSS_EN
  localparam logic [15:0] CRS  = 16'h07E0;
`else
  localparam logic [15:0] CRS  = 16'h001F;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  lcd_ball_box_if bus ();

  lcd_ball_box dut (
    .lcd_clk (clk),
    .sys_rst (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one pixel, then check the registered output one cycle later
  task automatic px(input logic de, input logic [15:0] rgb, input int x, input int y,
                    input logic [15:0] exp);
    @(negedge clk);
    bus.pre_de     = de;
    bus.pre_rgb    = rgb;
    bus.pixel_xpos = 11'(x);
    bus.pixel_ypos = 11'(y);
    @(posedge clk);
    #1;
    chk("post_de", {31'd0, bus.post_de}, {31'd0, de});
    chk($sformatf("post_rgb(%0d,%0d)", x, y), {16'd0, bus.post_rgb}, {16'd0, exp});
  endtask

  task automatic blank(input int n);
    @(negedge clk);
    bus.in_vsync = 1'b1;
    bus.pre_de   = 1'b0;
    bus.pre_rgb  = '0;
    repeat (n) @(negedge clk);
    bus.in_vsync = 1'b0;
  endtask

  task automatic red_block();
    for (int y = 50; y <= 59; y++)
      for (int x = 100; x <= 109; x++)
        px(1'b1, RED, x, y, RED);
  endtask

  task automatic chk_box(input logic v, input int x0, input int x1, input int y0, input int y1);
    chk("box_valid", {31'd0, bus.box_valid}, {31'd0, v});
    chk("x_min_o", {21'd0, bus.x_min_o}, 32'(x0));
    chk("x_max_o", {21'd0, bus.x_max_o}, 32'(x1));
    chk("y_min_o", {21'd0, bus.y_min_o}, 32'(y0));
    chk("y_max_o", {21'd0, bus.y_max_o}, 32'(y1));
  endtask

  initial begin
    logic        de;
    logic [15:0] rgb;

    rst            = 1'b1;
    bus.in_vsync   = 1'b1;
    bus.pre_de     = 1'b0;
    bus.pre_rgb    = '0;
    bus.pixel_xpos = '0;
    bus.pixel_ypos = '0;
    repeat (3) @(negedge clk);
    chk("rst post_de", {31'd0, bus.post_de}, 32'd0);
    chk("rst post_rgb", {16'd0, bus.post_rgb}, 32'd0);
    chk_box(1'b0, 0, 0, 0, 0);
    rst = 1'b0;

    // Frame A: 10x10 red block plus non-matching pixels
    blank(4);
    px(1'b1, 16'h0000, 5, 5, 16'h0000);
    px(1'b1, 16'hFFFF, 300, 300, 16'hFFFF);
    red_block();
    blank(4);
    chk_box(1'b1, 100, 109, 50, 59);

    // Frame B: overlay of the latched box, then only 63 matching pixels
    px(1'b1, BLU, 100, 55, GRN);
    px(1'b1, BLU, 101, 55, GRN);
    px(1'b1, BLU, 102, 55, BLU);
    px(1'b1, BLU,  99, 55, BLU);
    px(1'b1, BLU, 108, 55, GRN);
    px(1'b1, BLU, 109, 55, GRN);
    px(1'b1, BLU, 110, 55, BLU);
    px(1'b1, BLU, 104, 50, GRN);
    px(1'b1, BLU, 104, 51, GRN);
    px(1'b1, BLU, 104, 52, CRS);
    px(1'b1, BLU, 104, 54, CRS);
    px(1'b1, BLU, 100, 54, GRN);
    px(1'b1, BLU, 104, 59, GRN);
    px(1'b1, BLU, 104, 60, BLU);
    px(1'b0, 16'h0000, 100, 55, 16'h0000);
    for (int i = 0; i < 63; i++) px(1'b1, RED, 200 + i, 10, RED);
    blank(4);
    chk_box(1'b0, 100, 109, 50, 59);

    // Frame C: no overlay, random pass-through, then 64 hits at (0,0)
    px(1'b1, BLU, 100, 55, BLU);
    for (int i = 0; i < 40; i++) begin
      de  = 1'($urandom_range(0, 1));
      rgb = de ? (16'($urandom) | 16'h0400) : 16'h0000;
      px(de, rgb, $urandom_range(300, 1000), $urandom_range(300, 700), rgb);
    end
    for (int i = 0; i < 64; i++) px(1'b1, RED, 0, 0, RED);
    blank(4);
    chk_box(1'b1, 0, 0, 0, 0);

    // Frame D: degenerate box at the origin, bounds must not wrap
    for (int i = 0; i < 64; i++) px(1'b1, RED, 0, 0, GRN);
    px(1'b1, BLU, 1, 0, CRS);
    px(1'b1, BLU, 0, 1, CRS);
    px(1'b1, BLU, 2047, 0, BLU);
    px(1'b1, BLU, 0, 2047, BLU);
    px(1'b1, BLU, 2047, 2047, BLU);
    blank(4);
    chk_box(1'b1, 0, 0, 0, 0);

    // Frame E: reset mid-frame clears everything at once
    px(1'b1, BLU, 500, 500, BLU);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid rst post_de", {31'd0, bus.post_de}, 32'd0);
    chk("mid rst post_rgb", {16'd0, bus.post_rgb}, 32'd0);
    chk_box(1'b0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) px(1'b1, BLU, 600 + i, 500, BLU);
    blank(4);
    chk_box(1'b0, 0, 0, 0, 0);

    // First full frame after reset yields the box again
    red_block();
    blank(4);
    chk_box(1'b1, 100, 109, 50, 59);
    px(1'b1, BLU, 100, 55, GRN);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
